// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcodes, sequencer state encoding and a small opcode
// classification helper for the seq_alu datapath and its iterative unit.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_NOTA = 4'd1;
  localparam logic [3:0] OP_NOTB = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_MOD  = 4'd12;
  localparam logic [3:0] OP_SHL  = 4'd13;
  localparam logic [3:0] OP_SHR  = 4'd14;
  localparam logic [3:0] OP_CLR  = 4'd15;

  typedef enum logic [0:0] {IDLE = 1'b0, ITER = 1'b1} state_e;

  // Plain-vector aliases of the state enum for the state register.
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_ITER = ITER;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle of seq_alu.
//   start/opcode/a/b : request from the operand side (master drives)
//   busy/done        : handshake status (slave drives)
//   result/error     : registered response, valid from done
interface seq_alu_if #(parameter int WIDTH = 16);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             error;

  modport master (output start, opcode, a, b, input busy, done, result, error);
  modport slave  (input start, opcode, a, b, output busy, done, result, error);
endinterface

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative multiply / restoring divide unit.
//   clk, rst_n      : clock, async active-low reset
//   launch          : start an iteration run (operands on a_in/b_in)
//   launch_op       : opcode at launch (MUL loads b, DIV/MOD load a)
//   op_q, a_q, b_q  : operands/opcode held by the top for the whole run
//   busy            : ITER state
//   fin             : combinational, high during the final iteration cycle
//   res, err        : value to register on the edge that ends the run
//
// state | meaning
// IDLE  | waiting for launch
// ITER  | one multiply or quotient bit per clock, WIDTH clocks total
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             launch,
  input  logic [3:0]       launch_op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op_q,
  input  logic [WIDTH-1:0] a_q,
  input  logic [WIDTH-1:0] b_q,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] res,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  // hi: upper product half / partial remainder; lo: multiplier / dividend->quotient
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] hi_nx, lo_nx;

  logic             is_mul;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_x, add_y;
  logic             add_ci;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;

  assign is_mul  = (op_q == OP_MUL);
  assign shifted = {hi, lo[WIDTH-1]};

  // Single WIDTH+1-bit adder: MUL adds a into the upper half, DIV does the
  // trial subtract as shifted + ~b + 1 (carry out means no borrow).
  assign add_x  = is_mul ? {1'b0, hi} : shifted;
  assign add_y  = is_mul ? (lo[0] ? {1'b0, a_q} : '0) : ~{1'b0, b_q};
  assign add_ci = ~is_mul;
  assign sum    = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, add_ci};
  assign no_borrow = sum[WIDTH+1];

  always_comb begin
    if (is_mul) begin
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_nx = no_borrow ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], no_borrow};
    end
  end

  assign busy = (state == ST_ITER);
  assign fin  = busy && (cnt == LAST);
  assign res  = (op_q == OP_MOD) ? hi_nx : lo_nx;
  assign err  = is_mul && (|hi_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == ST_IDLE) begin
      if (launch) begin
        state <= ST_ITER;
        cnt   <= '0;
        hi    <= '0;
        lo    <= (launch_op == OP_MUL) ? b_in : a_in;
      end
    end else begin
      hi <= hi_nx;
      lo <= lo_nx;
      if (cnt == LAST) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: clocked WIDTH-bit ALU with start/busy/done handshake.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_alu_if slave (start/opcode/a/b in; busy/done/result/error out)
// Single-cycle ops write result/error/done on the accepting edge; MUL and
// DIV/MOD with b != 0 run WIDTH cycles in seq_alu_muldiv.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             done_q, error_q;
  logic [WIDTH-1:0] result_q;

  logic             busy, accept, launch;
  logic             mdu_fin, mdu_err;
  logic [WIDTH-1:0] mdu_res;

  assign accept = bus.start && !busy;
  assign launch = accept && is_iter_op(bus.opcode) && (bus.b != '0);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .launch    (launch),
    .launch_op (bus.opcode),
    .a_in      (bus.a),
    .b_in      (bus.b),
    .op_q      (op_q),
    .a_q       (a_q),
    .b_q       (b_q),
    .busy      (busy),
    .fin       (mdu_fin),
    .res       (mdu_res),
    .err       (mdu_err)
  );

  // single-cycle datapath, evaluated on the raw request
  logic [SW-1:0]    shamt;
  logic             sh_hi;
  logic [WIDTH-1:0] keep_mask;
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] sc_res;
  logic             sc_err;

  assign shamt = bus.b[SW-1:0];
  assign sh_hi = |bus.b[WIDTH-1:SW];
  // Bits of a that survive a left shift; anything outside is shifted out.
  assign keep_mask = sh_hi ? '0 : ({WIDTH{1'b1}} >> shamt);
  assign add_s = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_s = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH + 1)'(1);

  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (bus.opcode)
      OP_AND:  sc_res = bus.a & bus.b;
      OP_NOTA: sc_res = ~bus.a;
      OP_NOTB: sc_res = ~bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_NOR:  sc_res = ~(bus.a | bus.b);
      OP_NAND: sc_res = ~(bus.a & bus.b);
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_XNOR: sc_res = ~(bus.a ^ bus.b);
      OP_ADD: begin
        sc_res = add_s[WIDTH-1:0];
        sc_err = add_s[WIDTH];
      end
      OP_SUB: begin
        sc_res = sub_s[WIDTH-1:0];
        sc_err = ~sub_s[WIDTH];
      end
      OP_MUL:  sc_res = '0;          // only reached with b == 0
      OP_DIV: begin                  // only reached with b == 0
        sc_res = '1;
        sc_err = 1'b1;
      end
      OP_MOD: begin
        sc_res = bus.a;
        sc_err = 1'b1;
      end
      OP_SHL: begin
        sc_res = sh_hi ? '0 : (bus.a << shamt);
        sc_err = |(bus.a & ~keep_mask);
      end
      OP_SHR:  sc_res = sh_hi ? '0 : (bus.a >> shamt);
      default: sc_res = '0;          // CLR
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mdu_fin) begin
        result_q <= mdu_res;
        error_q  <= mdu_err;
        done_q   <= 1'b1;
      end else if (accept) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.opcode;
        if (!launch) begin
          result_q <= sc_res;
          error_q  <= sc_err;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           due;
    string        name;
  } exp_t;

  exp_t q[$];

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected done", 32'(bus.result), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, " result"}, 32'(bus.result), 32'(e.res));
        chk({e.name, " error"},  32'(bus.error),  32'(e.err));
        chk({e.name, " cycle"},  32'(cyc),        32'(e.due));
      end
    end
  end

  // lat = edges between the accepting edge and the edge that raises done
  task automatic drive(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic err,
                       input int lat);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.a      = a;
    bus.b      = b;
    e.res  = res;
    e.err  = err;
    e.due  = cyc + 1 + lat;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL done timeout: %0d responses outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic err,
                       input int lat);
    drive(nm, op, a, b, res, err, lat);
    idle();
    wait_empty();
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.opcode = OP_AND;
    bus.a      = '0;
    bus.b      = '0;
    #12;
    chk("reset busy",   32'(bus.busy),   32'h0);
    chk("reset done",   32'(bus.done),   32'h0);
    chk("reset result", 32'(bus.result), 32'h0);
    chk("reset error",  32'(bus.error),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("and",   OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 0);
    issue("clr",   OP_CLR, 16'h1234, 16'h5678, 16'h0000, 1'b0, 0);
    issue("nota",  OP_NOTA, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 0);
    issue("xnor",  OP_XNOR, 16'hFF00, 16'h0FF0, 16'h0F0F, 1'b0, 0);
    issue("add",   OP_ADD, 16'd40000, 16'd50001, 16'd24465, 1'b1, 0);
    issue("sub",   OP_SUB, 16'd3390, 16'd21193, 16'd47733, 1'b1, 0);
    issue("sub ok", OP_SUB, 16'd21193, 16'd3390, 16'd17803, 1'b0, 0);
    issue("mul300", OP_MUL, 16'd300, 16'd300, 16'd24464, 1'b1, 16);
    issue("mul255", OP_MUL, 16'd255, 16'd255, 16'd65025, 1'b0, 16);
    issue("mul x0", OP_MUL, 16'd7, 16'd0, 16'd0, 1'b0, 0);
    issue("div",   OP_DIV, 16'd21193, 16'd3390, 16'd6, 1'b0, 16);
    issue("mod",   OP_MOD, 16'd21193, 16'd3390, 16'd853, 1'b0, 16);
    issue("div lt", OP_DIV, 16'd40000, 16'd50001, 16'd0, 1'b0, 16);
    issue("mod lt", OP_MOD, 16'd40000, 16'd50001, 16'd40000, 1'b0, 16);
    issue("div0",  OP_DIV, 16'd5, 16'd0, 16'hFFFF, 1'b1, 0);
    issue("mod0",  OP_MOD, 16'd5, 16'd0, 16'd5, 1'b1, 0);
    issue("shl1",  OP_SHL, 16'h8001, 16'd1, 16'h0002, 1'b1, 0);
    issue("shl ok", OP_SHL, 16'h0003, 16'd4, 16'h0030, 1'b0, 0);
    issue("shr15", OP_SHR, 16'h8000, 16'd15, 16'h0001, 1'b0, 0);
    issue("shl16", OP_SHL, 16'h0001, 16'd16, 16'h0000, 1'b1, 0);

    // back-to-back single-cycle ops, one per clock
    drive("b2b add",  OP_ADD,  16'd1, 16'd2, 16'd3, 1'b0, 0);
    drive("b2b xor",  OP_XOR,  16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0, 0);
    drive("b2b nand", OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 0);
    idle();
    wait_empty();

    // start while busy is ignored
    drive("mul busy", OP_MUL, 16'd300, 16'd300, 16'd24464, 1'b1, 16);
    idle();
    chk("busy after accept", 32'(bus.busy), 32'h1);
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = OP_DIV;
    bus.a      = 16'd5;
    bus.b      = 16'd1;
    idle();
    wait_empty();
    chk("busy after done", 32'(bus.busy), 32'h0);

    // reset mid-MUL aborts with no done
    drive("mul abort", OP_MUL, 16'd255, 16'd255, 16'd65025, 1'b0, 16);
    idle();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort busy",   32'(bus.busy),   32'h0);
    chk("abort done",   32'(bus.done),   32'h0);
    chk("abort result", 32'(bus.result), 32'h0);
    chk("abort error",  32'(bus.error),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue("post rst", OP_ADD, 16'd1, 16'd1, 16'd2, 1'b0, 0);
    issue("post mul", OP_MUL, 16'd3, 16'd5, 16'd15, 1'b0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
